// File: rtl/vram_pkg.sv
// vram_pkg: shared types for the VRAM arbiter slice.
// Pixel/address widths, FSM states and the registered VRAM command bundle.
package vram_pkg;

  localparam int PIX_W      = 24;
  localparam int ADDR_W     = 16;
  localparam int PIXELS_DEF = 64000;

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VREAD,
    S_VCAP,
    S_CREAD,
    S_CCAP,
    S_CWRITE
  } state_t;

  typedef struct packed {
    logic   req;
    logic   rw;
    addr_t  addr;
    pixel_t wdata;
  } vram_cmd_t;

  function automatic addr_t scan_next(
    input addr_t a,
    input int    pixels
  );
    if (a == addr_t'(pixels - 1)) return '0;
    return a + addr_t'(1);
  endfunction

endpackage

// File: rtl/vram_prefetch_fifo.sv
// vram_prefetch_fifo: small synchronous FIFO with flush, feeding scanout.
// Pop on empty is ignored; flush wins over push and pop.
module vram_prefetch_fifo
  import vram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  pixel_t                 wdata,
  input  logic                   pop,
  output pixel_t                 rdata,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pixel_t        mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + AW'(1);
      if (do_pop)  head <= head + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[tail] <= wdata;
  end

  assign rdata = valid ? mem[head] : '0;

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one VRAM page between CPU and prefetched scanout.
// Define VRAM_ARB_STARVE_GUARD_EN to force a CPU slot after STARVE_LIMIT video grants.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int PIXELS     = PIXELS_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int LOW_WATER  = 1
`ifdef VRAM_ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIMIT = 8
`endif
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_cpu_request,
  input  logic        i_cpu_rw,
  input  logic [15:0] i_cpu_address,
  input  logic [23:0] i_cpu_wdata,
  output logic [23:0] o_cpu_rdata,
  output logic        o_cpu_ready,
  input  logic        i_video_vsync,
  input  logic        i_video_pop,
  output logic [23:0] o_video_rdata,
  output logic        o_video_valid,
  output logic [15:0] o_vram_address,
  output logic        o_vram_request,
  output logic        o_vram_rw,
  output logic [23:0] o_vram_wdata,
  input  logic [23:0] i_vram_rdata
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] LW = (CW+1)'(LOW_WATER);
  localparam logic [CW:0] FD = (CW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(PIXELS);

  state_t        state;
  state_t        state_nx;
  vram_cmd_t     cmd;
  addr_t         scan;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          inflight;
  logic          cpu_pend;
  logic          cpu_oor;
  logic          starve;
  logic          grant_v;
  logic          grant_c;
  logic          push;

  // The in-flight video read holds a FIFO slot so a push never overflows.
  assign inflight = (state == S_VREAD) || (state == S_VCAP);
  assign occ      = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign cpu_pend = i_cpu_request && !o_cpu_ready;
  assign cpu_oor  = {1'b0, i_cpu_address} >= LIMIT;
  assign push     = (state == S_VCAP) && !i_video_vsync;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt;

  assign starve = cpu_pend && (starve_cnt >= SLIM);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      starve_cnt <= '0;
    end else if (grant_c) begin
      starve_cnt <= '0;
    end else if (grant_v && cpu_pend && starve_cnt < SLIM) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end
`else
  assign starve = 1'b0;
`endif

  // A vsync cycle never grants video: scan is being rewound on that edge.
  always_comb begin
    grant_v = 1'b0;
    grant_c = 1'b0;
    if (state == S_IDLE) begin
      if (starve) begin
        grant_c = 1'b1;
      end else if (occ <= LW) begin
        grant_v = !i_video_vsync;
      end else if (cpu_pend) begin
        grant_c = 1'b1;
      end else if (occ < FD) begin
        grant_v = !i_video_vsync;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (grant_v) begin
          state_nx = S_VREAD;
        end else if (grant_c && !cpu_oor) begin
          state_nx = i_cpu_rw ? S_CWRITE : S_CREAD;
        end
      end
      S_VREAD:  state_nx = i_video_vsync ? S_IDLE : S_VCAP;
      S_VCAP:   state_nx = S_IDLE;
      S_CREAD:  state_nx = S_CCAP;
      S_CCAP:   state_nx = S_IDLE;
      S_CWRITE: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state       <= S_IDLE;
      cmd         <= '0;
      scan        <= '0;
      o_cpu_ready <= 1'b0;
      o_cpu_rdata <= '0;
    end else begin
      state       <= state_nx;
      cmd.req     <= 1'b0;
      o_cpu_ready <= 1'b0;
      if (grant_v) begin
        cmd.req  <= 1'b1;
        cmd.rw   <= 1'b0;
        cmd.addr <= scan;
      end
      if (grant_c && !cpu_oor) begin
        cmd.req   <= 1'b1;
        cmd.rw    <= i_cpu_rw;
        cmd.addr  <= i_cpu_address;
        cmd.wdata <= i_cpu_wdata;
      end
      if (grant_c && cpu_oor) begin
        o_cpu_ready <= 1'b1;
        if (!i_cpu_rw) o_cpu_rdata <= '0;
      end
      if (state == S_CWRITE) o_cpu_ready <= 1'b1;
      if (state == S_CCAP) begin
        o_cpu_ready <= 1'b1;
        o_cpu_rdata <= i_vram_rdata;
      end
      if (i_video_vsync) begin
        scan <= '0;
      end else if (push) begin
        scan <= scan_next(scan, PIXELS);
      end
    end
  end

  assign o_vram_request = cmd.req;
  assign o_vram_rw      = cmd.rw;
  assign o_vram_address = cmd.addr;
  assign o_vram_wdata   = cmd.wdata;

  vram_prefetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clock),
    .rst   (i_reset),
    .flush (i_video_vsync),
    .push  (push),
    .wdata (i_vram_rdata),
    .pop   (i_video_pop),
    .rdata (o_video_rdata),
    .valid (o_video_valid),
    .count (count)
  );

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed vectors plus multi-cycle sequences.
// A small second instance (PIXELS=8) exercises the scan wrap.
module tb_vram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cpu_req;
  logic        cpu_rw;
  logic [15:0] cpu_addr;
  logic [23:0] cpu_wdata;
  logic [23:0] cpu_rdata;
  logic        cpu_ready;
  logic        vsync;
  logic        pop;
  logic [23:0] video_rdata;
  logic        video_valid;
  logic [15:0] vram_addr;
  logic        vram_req;
  logic        vram_rw;
  logic [23:0] vram_wdata;
  logic [23:0] vram_rdata;

  logic        rst2;
  logic        pop2;
  logic [23:0] w_cpu_rdata;
  logic        w_cpu_ready;
  logic [23:0] w_video_rdata;
  logic        w_video_valid;
  logic [15:0] w_addr;
  logic        w_req;
  logic        w_rw;
  logic [23:0] w_wdata;
  logic [23:0] w_rdata;

  vram_arbiter u_dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_cpu_request  (cpu_req),
    .i_cpu_rw       (cpu_rw),
    .i_cpu_address  (cpu_addr),
    .i_cpu_wdata    (cpu_wdata),
    .o_cpu_rdata    (cpu_rdata),
    .o_cpu_ready    (cpu_ready),
    .i_video_vsync  (vsync),
    .i_video_pop    (pop),
    .o_video_rdata  (video_rdata),
    .o_video_valid  (video_valid),
    .o_vram_address (vram_addr),
    .o_vram_request (vram_req),
    .o_vram_rw      (vram_rw),
    .o_vram_wdata   (vram_wdata),
    .i_vram_rdata   (vram_rdata)
  );

  vram_arbiter #(.PIXELS(8)) u_wrap (
    .i_clock        (clk),
    .i_reset        (rst2),
    .i_cpu_request  (1'b0),
    .i_cpu_rw       (1'b0),
    .i_cpu_address  (16'h0),
    .i_cpu_wdata    (24'h0),
    .o_cpu_rdata    (w_cpu_rdata),
    .o_cpu_ready    (w_cpu_ready),
    .i_video_vsync  (1'b0),
    .i_video_pop    (pop2),
    .o_video_rdata  (w_video_rdata),
    .o_video_valid  (w_video_valid),
    .o_vram_address (w_addr),
    .o_vram_request (w_req),
    .o_vram_rw      (w_rw),
    .o_vram_wdata   (w_wdata),
    .i_vram_rdata   (w_rdata)
  );

  // VRAM page model: registered read, pixel i initialised to value i.
  logic [23:0] vmem [0:65535];

  always @(posedge clk) begin
    if (vram_req) begin
      if (vram_rw) vmem[vram_addr] <= vram_wdata;
      else         vram_rdata <= vmem[vram_addr];
    end
  end

  always @(posedge clk) begin
    if (w_req) w_rdata <= {8'h0, w_addr};
  end

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [23:0] wdata;
    logic [23:0] exp_rdata;
    int          exp_lat;
    int          exp_nreq;
  } vec_t;

  vec_t vt [8];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_op(
    input  vec_t        v,
    output int          lat,
    output int          nreq,
    output logic [15:0] ra,
    output logic        rrw,
    output logic [23:0] rwd,
    output logic [23:0] rd,
    output logic        dbl
  );
    cpu_rw    = v.rw;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    cpu_req   = 1'b1;
    lat  = -1;
    nreq = 0;
    ra   = '0;
    rrw  = 1'b0;
    rwd  = '0;
    rd   = '0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (vram_req) begin
        nreq++;
        ra  = vram_addr;
        rrw = vram_rw;
        rwd = vram_wdata;
      end
      if (cpu_ready) begin
        lat = k;
        rd  = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
    tick();
    dbl = cpu_ready | vram_req;
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_vram_req"},  32'(vram_req), 0);
    chk({pfx, "_vram_addr"}, 32'(vram_addr), 0);
    chk({pfx, "_vram_rw"},   32'(vram_rw), 0);
    chk({pfx, "_vram_wd"},   32'(vram_wdata), 0);
    chk({pfx, "_ready"},     32'(cpu_ready), 0);
    chk({pfx, "_rdata"},     32'(cpu_rdata), 0);
    chk({pfx, "_vvalid"},    32'(video_valid), 0);
    chk({pfx, "_vrdata"},    32'(video_rdata), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          nreq;
    logic [15:0] ra;
    logic        rrw;
    logic [23:0] rwd;
    logic [23:0] rd;
    logic        dbl;
    logic [15:0] seen [$];
    int          nv;
    int          nready;
    logic        cpu_seen;

    vt[0] = '{1'b1, 16'd100,   24'hABCDEF, 24'h0,      2, 1};
    vt[1] = '{1'b0, 16'd100,   24'h0,      24'hABCDEF, 3, 1};
    vt[2] = '{1'b1, 16'd63999, 24'h123456, 24'h0,      2, 1};
    vt[3] = '{1'b0, 16'd63999, 24'h0,      24'h123456, 3, 1};
    vt[4] = '{1'b0, 16'd64000, 24'h0,      24'h0,      1, 0};
    vt[5] = '{1'b1, 16'd65535, 24'hFFFFFF, 24'h0,      1, 0};
    vt[6] = '{1'b0, 16'd0,     24'h0,      24'h0,      3, 1};
    vt[7] = '{1'b0, 16'd5,     24'h0,      24'h5,      3, 1};

    for (int i = 0; i < 65536; i++) vmem[i] = 24'(i);

    rst       = 1'b1;
    rst2      = 1'b1;
    cpu_req   = 1'b0;
    cpu_rw    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    vsync     = 1'b0;
    pop       = 1'b0;
    pop2      = 1'b0;
    repeat (2) tick();
    chk_outputs_zero("rst");
    rst = 1'b0;

    // Idle fill: exactly four sequential reads.
    repeat (30) begin
      tick();
      if (vram_req) begin
        seen.push_back(vram_addr);
        chk("fill_rw", 32'(vram_rw), 0);
      end
    end
    chk("fill_nreq", seen.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < seen.size()) chk("fill_addr", 32'(seen[i]), i);
    end
    chk("fill_valid", 32'(video_valid), 1);
    chk("fill_head", 32'(video_rdata), 0);

    for (int v = 0; v < 8; v++) begin
      cpu_op(vt[v], lat, nreq, ra, rrw, rwd, rd, dbl);
      chk($sformatf("v%0d_lat", v), lat, vt[v].exp_lat);
      chk($sformatf("v%0d_nreq", v), nreq, vt[v].exp_nreq);
      chk($sformatf("v%0d_dbl", v), 32'(dbl), 0);
      if (vt[v].exp_nreq != 0) begin
        chk($sformatf("v%0d_addr", v), 32'(ra), 32'(vt[v].addr));
        chk($sformatf("v%0d_rw", v), 32'(rrw), 32'(vt[v].rw));
        if (vt[v].rw) chk($sformatf("v%0d_wd", v), 32'(rwd), 32'(vt[v].wdata));
      end
      if (!vt[v].rw) chk($sformatf("v%0d_rd", v), 32'(rd), 32'(vt[v].exp_rdata));
    end

    // Pop every 4 cycles while CPU writes stream in.
    fork
      begin
        int exp_px = 0;
        for (int p = 0; p < 40; p++) begin
          for (int j = 0; j < 4; j++) begin
            chk("stream_valid", 32'(video_valid), 1);
            if (j == 0) begin
              chk("stream_px", 32'(video_rdata), exp_px);
              pop = 1'b1;
              exp_px++;
            end
            tick();
            pop = 1'b0;
          end
        end
      end
      begin
        for (int w = 0; w < 12; w++) begin
          logic done = 1'b0;
          cpu_rw    = 1'b1;
          cpu_addr  = 16'(3000 + w);
          cpu_wdata = 24'(3000 + w);
          cpu_req   = 1'b1;
          for (int k = 0; k < 40; k++) begin
            tick();
            if (cpu_ready) begin
              done = 1'b1;
              break;
            end
          end
          chk("stream_wr_done", 32'(done), 1);
          cpu_req = 1'b0;
          tick();
        end
      end
    join

    // vsync while a video read is in flight.
    repeat (20) tick();
    pop = 1'b1;
    tick();
    pop = 1'b0;
    tick();
    chk("vs_inflight_req", 32'(vram_req), 1);
    chk("vs_inflight_rw", 32'(vram_rw), 0);
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    chk("vs_flush_valid", 32'(video_valid), 0);
    tick();
    chk("vs_next_req", 32'(vram_req), 1);
    chk("vs_next_addr", 32'(vram_addr), 0);
    repeat (2) tick();
    chk("vs_refill_valid", 32'(video_valid), 1);
    chk("vs_refill_head", 32'(video_rdata), 0);

    // Reset in the capture cycle of a CPU read.
    repeat (20) tick();
    cpu_rw   = 1'b0;
    cpu_addr = 16'd7;
    cpu_req  = 1'b1;
    tick();
    chk("rc_req", 32'(vram_req), 1);
    tick();
    #1;
    rst     = 1'b1;
    cpu_req = 1'b0;
    #1;
    chk_outputs_zero("rc");
    tick();
    rst    = 1'b0;
    nready = 0;
    repeat (12) begin
      tick();
      if (cpu_ready) nready++;
    end
    chk("rc_no_ready", nready, 0);

    // Starvation: scanout pops every cycle while the CPU waits.
    rst = 1'b1;
    tick();
    cpu_rw    = 1'b1;
    cpu_addr  = 16'd200;
    cpu_wdata = 24'h000200;
    cpu_req   = 1'b1;
    rst       = 1'b0;
    nv        = 0;
    cpu_seen  = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (vram_req && vram_rw) cpu_seen = 1'b1;
      if (vram_req && !vram_rw && !cpu_seen) nv++;
      if (cpu_ready) cpu_req = 1'b0;
      pop = video_valid;
    end
    cpu_req = 1'b0;
    pop     = 1'b0;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    chk("starve_cpu_granted", 32'(cpu_seen), 1);
    chk("starve_video_grants", nv, 8);
`else
    chk("starve_cpu_waits", 32'(cpu_seen), 0);
    chk("starve_video_busy", 32'(nv >= 15), 1);
`endif

    // Scan wrap on the PIXELS=8 instance.
    seen.delete();
    rst2 = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (w_req && seen.size() < 11) seen.push_back(w_addr);
      pop2 = w_video_valid;
    end
    pop2 = 1'b0;
    chk("wrap_nreq", 32'(seen.size() == 11), 1);
    for (int i = 0; i < 11; i++) begin
      if (i < seen.size()) chk("wrap_addr", 32'(seen[i]), i % 8);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
